// File: rtl/max_score_ctrl.sv
// Sequencer for the registered max-reduction tree: pulses tree init, admits columns, tracks them
// through the tree latency and keeps the running best score and its column index.
module max_score_ctrl #(
    parameter int unsigned DATA_WIDTH = 18,
    parameter int unsigned LATENCY    = 2,
    parameter int unsigned COL_W      = 13
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  col_valid,
    input  logic                  col_last,
    output logic                  col_ready,
    output logic                  tree_init,
    input  logic [DATA_WIDTH-1:0] tree_result,
    output logic                  busy,
    output logic [DATA_WIDTH-1:0] score,
    output logic [COL_W-1:0]      best_col,
    output logic                  col_ovf,
    output logic                  score_valid,
    input  logic                  score_ready
);

    typedef enum logic [2:0] {StIdle, StInit, StRun, StDrain, StDone} state_e;

    localparam logic [COL_W-1:0] ColMax = '1;

    state_e                  state_q, state_d;
    logic                    pipe_vld_q [LATENCY];
    logic [COL_W-1:0]        pipe_tag_q [LATENCY];
    logic [COL_W-1:0]        col_cnt_q;
    logic                    col_ovf_q;
    logic [DATA_WIDTH-1:0]   best_q;
    logic [COL_W-1:0]        best_col_q;
    logic                    accept;
    logic                    pending;
    logic                    update;

    assign accept = col_valid & col_ready;

    // Columns still in flight ahead of the last stage; the last stage is compared this cycle.
    always_comb begin
        pending = 1'b0;
        for (int i = 0; i < int'(LATENCY) - 1; i++) begin
            pending = pending | pipe_vld_q[i];
        end
    end

    // Negative candidates behave as zero in the tree and can never beat best.
    assign update = pipe_vld_q[LATENCY-1] && !tree_result[DATA_WIDTH-1] &&
                    (tree_result[DATA_WIDTH-2:0] > best_q[DATA_WIDTH-2:0]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StInit;
            StInit:  state_d = StRun;
            StRun:   if (accept && col_last) state_d = StDrain;
            StDrain: if (!pending) state_d = StDone;
            StDone:  if (score_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        tree_init   = (state_q == StInit);
        col_ready   = (state_q == StRun);
        score_valid = (state_q == StDone);
        busy        = (state_q != StIdle);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(LATENCY); i++) begin
                pipe_vld_q[i] <= 1'b0;
                pipe_tag_q[i] <= '0;
            end
        end else begin
            pipe_vld_q[0] <= accept;
            pipe_tag_q[0] <= col_cnt_q;
            for (int i = 1; i < int'(LATENCY); i++) begin
                pipe_vld_q[i] <= pipe_vld_q[i-1];
                pipe_tag_q[i] <= pipe_tag_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_cnt_q  <= '0;
            col_ovf_q  <= 1'b0;
            best_q     <= '0;
            best_col_q <= '0;
        end else if (state_q == StInit) begin
            col_cnt_q  <= '0;
            col_ovf_q  <= 1'b0;
            best_q     <= '0;
            best_col_q <= '0;
        end else begin
            if (accept) begin
                if (col_cnt_q == ColMax) begin
                    col_ovf_q <= 1'b1;
                end else begin
                    col_cnt_q <= col_cnt_q + 1'b1;
                end
            end
            if (update) begin
                best_q     <= tree_result;
                best_col_q <= pipe_tag_q[LATENCY-1];
            end
        end
    end

    assign score    = best_q;
    assign best_col = best_col_q;
    assign col_ovf  = col_ovf_q;

endmodule

// File: tb/tb_max_score_ctrl.sv
// Scoreboard bench: two controllers (13-bit and 3-bit column counters) share one stimulus stream
// and a behavioural two-stage tree; a monitor pops expected results on every result handshake.
module tb_max_score_ctrl;

    localparam int DW = 18;

    typedef struct packed {
        logic [DW-1:0] score;
        logic [12:0]   col_a;
        logic [2:0]    col_b;
        logic          ovf_a;
        logic          ovf_b;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n, start, col_valid, col_last, score_ready;
    logic [DW-1:0] col_data;
    logic [DW-1:0] st1 = '0;
    logic [DW-1:0] tree_result = '0;

    logic          col_ready_a, tree_init_a, busy_a, col_ovf_a, score_valid_a;
    logic [DW-1:0] score_a;
    logic [12:0]   best_col_a;
    logic          col_ready_b, tree_init_b, busy_b, col_ovf_b, score_valid_b;
    logic [DW-1:0] score_b;
    logic [2:0]    best_col_b;

    exp_t          sb[$];
    exp_t          e;
    logic [DW-1:0] dq[$];
    bit            vq[$];
    int            n_checks = 0;
    int            n_fail   = 0;
    int            cyc;

    max_score_ctrl #(.DATA_WIDTH(DW), .LATENCY(2), .COL_W(13)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .col_valid(col_valid), .col_last(col_last),
        .col_ready(col_ready_a), .tree_init(tree_init_a), .tree_result(tree_result),
        .busy(busy_a), .score(score_a), .best_col(best_col_a), .col_ovf(col_ovf_a),
        .score_valid(score_valid_a), .score_ready(score_ready)
    );

    max_score_ctrl #(.DATA_WIDTH(DW), .LATENCY(2), .COL_W(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .col_valid(col_valid), .col_last(col_last),
        .col_ready(col_ready_b), .tree_init(tree_init_b), .tree_result(tree_result),
        .busy(busy_b), .score(score_b), .best_col(best_col_b), .col_ovf(col_ovf_b),
        .score_valid(score_valid_b), .score_ready(score_ready)
    );

    always #5 clk = ~clk;

    // Behavioural tree: two register layers, cleared by the init pulse, not by reset.
    always @(posedge clk) begin
        if (tree_init_a) begin
            st1         <= '0;
            tree_result <= '0;
        end else begin
            st1         <= col_data;
            tree_result <= st1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && score_valid_a && score_ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_result: got score %0h with no expectation", score_a);
            end else begin
                e = sb.pop_front();
                chk("score_a", 32'(score_a), 32'(e.score));
                chk("best_col_a", 32'(best_col_a), 32'(e.col_a));
                chk("col_ovf_a", 32'(col_ovf_a), 32'(e.ovf_a));
                chk("score_valid_b", 32'(score_valid_b), 32'd1);
                chk("score_b", 32'(score_b), 32'(e.score));
                chk("best_col_b", 32'(best_col_b), 32'(e.col_b));
                chk("col_ovf_b", 32'(col_ovf_b), 32'(e.ovf_b));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [DW-1:0] s, input logic [12:0] ca, input logic [2:0] cb,
                            input logic oa, input logic ob);
        exp_t x;
        x.score = s;
        x.col_a = ca;
        x.col_b = cb;
        x.ovf_a = oa;
        x.ovf_b = ob;
        sb.push_back(x);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, 32'(busy_a | busy_b), 32'd0);
        chk({tag, "_col_ready"}, 32'(col_ready_a | col_ready_b), 32'd0);
        chk({tag, "_tree_init"}, 32'(tree_init_a | tree_init_b), 32'd0);
        chk({tag, "_score_valid"}, 32'(score_valid_a | score_valid_b), 32'd0);
        chk({tag, "_score"}, 32'(score_a | score_b), 32'd0);
        chk({tag, "_best_col"}, 32'(best_col_a) | 32'(best_col_b), 32'd0);
        chk({tag, "_col_ovf"}, 32'(col_ovf_a | col_ovf_b), 32'd0);
    endtask

    task automatic begin_task();
        start = 1'b1;
        step();
        chk("init_pulse", 32'(tree_init_a), 32'd1);
        start = 1'b0;
        step();
        chk("init_one_cycle", 32'(tree_init_a), 32'd0);
        chk("run_col_ready", 32'(col_ready_a), 32'd1);
    endtask

    task automatic send_cols();
        for (int i = 0; i < dq.size(); i++) begin
            col_valid = vq[i];
            col_last  = (i == dq.size() - 1);
            col_data  = dq[i];
            step();
        end
        col_valid = 1'b0;
        col_last  = 1'b0;
        col_data  = '0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!score_valid_a && n < 20) begin
            step();
            n++;
        end
        if (!score_valid_a) begin
            n_checks++;
            n_fail++;
            $display("FAIL done_timeout: score_valid still 0 after %0d cycles", n);
        end
    endtask

    task automatic finish_task();
        wait_done(cyc);
        step();
        chk("back_to_idle", 32'(busy_a), 32'd0);
    endtask

    initial begin
        rst_n       = 1'b0;
        start       = 1'b0;
        col_valid   = 1'b0;
        col_last    = 1'b0;
        col_data    = '0;
        score_ready = 1'b1;
        #12;
        chk_zero("reset");
        rst_n = 1'b1;
        step();

        // T1: ties keep the earliest column; result three cycles after the last column
        begin_task();
        dq = '{18'd5, 18'd9, 18'd9, 18'd3};
        vq = '{1, 1, 1, 1};
        push_exp(18'd9, 13'd1, 3'd1, 1'b0, 1'b0);
        send_cols();
        wait_done(cyc);
        chk("t1_latency", 32'(cyc), 32'd2);
        step();
        chk("t1_idle", 32'(busy_a), 32'd0);

        // T2: negative candidates never update; full positive magnitude does
        begin_task();
        dq = '{18'h20005, 18'h3FFFF, 18'h20000};
        vq = '{1, 1, 1};
        push_exp(18'd0, 13'd0, 3'd0, 1'b0, 1'b0);
        send_cols();
        finish_task();
        begin_task();
        dq = '{18'd3, 18'h1FFFF, 18'h1FFFE};
        vq = '{1, 1, 1};
        push_exp(18'h1FFFF, 13'd1, 3'd1, 1'b0, 1'b0);
        send_cols();
        finish_task();

        // T3: bubbles carry large junk data that must be ignored and must not consume tags
        begin_task();
        dq = '{18'd2, 18'd100, 18'd7, 18'd200, 18'd4};
        vq = '{1, 0, 1, 0, 1};
        push_exp(18'd7, 13'd1, 3'd1, 1'b0, 1'b0);
        send_cols();
        finish_task();

        // T4: consumer stalls; result holds, start is ignored
        score_ready = 1'b0;
        begin_task();
        dq = '{18'd4, 18'd6};
        vq = '{1, 1};
        push_exp(18'd6, 13'd1, 3'd1, 1'b0, 1'b0);
        send_cols();
        wait_done(cyc);
        for (int i = 0; i < 10; i++) begin
            start = 1'b1;
            step();
            chk("t4_valid_held", 32'(score_valid_a), 32'd1);
            chk("t4_score_held", 32'(score_a), 32'd6);
            chk("t4_col_held", 32'(best_col_a), 32'd1);
            chk("t4_no_ready", 32'(col_ready_a), 32'd0);
        end
        start       = 1'b0;
        score_ready = 1'b1;
        step();
        chk("t4_idle", 32'(busy_a), 32'd0);

        // T5: asynchronous reset mid-task, then a clean task
        begin_task();
        for (int i = 0; i < 3; i++) begin
            col_valid = 1'b1;
            col_data  = DW'(50 + 10 * i);
            step();
        end
        col_valid = 1'b0;
        col_data  = '0;
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("t5_reset");
        #1;
        rst_n = 1'b1;
        step();
        chk("t5_idle_no_init", 32'(tree_init_a), 32'd0);
        begin_task();
        dq = '{18'd1, 18'd2};
        vq = '{1, 1};
        push_exp(18'd2, 13'd1, 3'd1, 1'b0, 1'b0);
        send_cols();
        finish_task();

        // T6: ten columns; the 3-bit counter saturates at 7
        begin_task();
        dq = '{18'd1, 18'd2, 18'd3, 18'd4, 18'd5, 18'd6, 18'd7, 18'd8, 18'd9, 18'd20};
        vq = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
        push_exp(18'd20, 13'd9, 3'd7, 1'b0, 1'b1);
        send_cols();
        finish_task();

        repeat (3) step();
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
